// File: rtl/kyber_encode_pkg.sv
// Shared constants, state type and helpers for the sequential ByteEncode_d engine.
package kyber_encode_pkg;

    localparam int unsigned N_COEF = 256;
    localparam int unsigned D_MAX  = 12;
    localparam int unsigned ACC_W  = 20;

    typedef enum logic [1:0] {IDLE, RUN, DONE} enc_state_t;

    // 256 coefficients of d bits each pack into exactly 32*d bytes.
    function automatic logic [10:0] bytes_per_poly(input logic [3:0] d);
        return {2'b00, d, 5'b00000};
    endfunction

endpackage

// File: rtl/encode_ctrl_if.sv
// Command, coefficient-input and byte-output handshake bundle of the encoder.
interface encode_ctrl_if;

    logic        start;
    logic [3:0]  d;
    logic [2:0]  npoly;
    logic        in_valid;
    logic [15:0] in_coef;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, d, npoly, in_valid, in_coef, out_ready,
        input  in_ready, out_valid, out_byte, out_last, busy, done, err
    );

    modport slave (
        input  start, d, npoly, in_valid, in_coef, out_ready,
        output in_ready, out_valid, out_byte, out_last, busy, done, err
    );

endinterface

// File: rtl/encode_packer.sv
// LSB-first bit accumulator: appends d masked coefficient bits, drains whole bytes.
module encode_packer
    import kyber_encode_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic [3:0]       d_i,
    input  logic             accept_i,
    input  logic [D_MAX-1:0] coef_i,
    input  logic             emit_i,
    output logic [4:0]       acc_bits_o,
    output logic [7:0]       byte_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [4:0]       acc_bits_q, acc_bits_d;
    logic [D_MAX-1:0] mask;
    logic [ACC_W-1:0] coef_shifted;

    // Accept only happens with fewer than 8 pending bits, so the shift never exceeds 7.
    always_comb begin
        mask         = D_MAX'((32'd1 << d_i) - 32'd1);
        coef_shifted = ACC_W'(coef_i & mask) << acc_bits_q;
    end

    always_comb begin
        acc_d      = acc_q;
        acc_bits_d = acc_bits_q;
        if (clear_i) begin
            acc_d      = '0;
            acc_bits_d = '0;
        end else if (accept_i) begin
            acc_d      = acc_q | coef_shifted;
            acc_bits_d = acc_bits_q + {1'b0, d_i};
        end else if (emit_i) begin
            acc_d      = acc_q >> 8;
            acc_bits_d = acc_bits_q - 5'd8;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            acc_bits_q <= '0;
        end else begin
            acc_q      <= acc_d;
            acc_bits_q <= acc_bits_d;
        end
    end

    assign acc_bits_o = acc_bits_q;
    assign byte_o     = acc_q[7:0];

endmodule

// File: rtl/encode_ctrl.sv
// ByteEncode_d scheduler: command legality, FSM, coefficient/byte counters and handshakes.
module encode_ctrl
    import kyber_encode_pkg::*;
#(
    parameter int unsigned N_POLY_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    encode_ctrl_if.slave  bus
);

    enc_state_t  state_q, state_d;
    logic [3:0]  d_q, d_d;
    logic [2:0]  npoly_q, npoly_d;
    logic [10:0] coef_cnt_q, coef_cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [10:0] last_at_q, last_at_d;
    logic        err_q, err_d;

    logic [4:0]  acc_bits;
    logic [7:0]  acc_byte;
    logic [10:0] coef_total;
    logic        start_legal;
    logic        clear;
    logic        in_ready;
    logic        out_valid;
    logic        out_last;
    logic        accept;
    logic        emit;
    logic        unused_coef_hi;

    assign unused_coef_hi = ^bus.in_coef[15:D_MAX];

    assign start_legal = (bus.d != 4'd0) && (32'(bus.d) <= D_MAX) &&
                         (bus.npoly != 3'd0) && (32'(bus.npoly) <= N_POLY_MAX);

    assign coef_total = 11'(32'(npoly_q) * N_COEF);

    // acc_bits < 8 and acc_bits >= 8 never hold together, so accept and emit are exclusive.
    assign in_ready  = (state_q == RUN) && (acc_bits < 5'd8) && (coef_cnt_q < coef_total);
    assign out_valid = (state_q == RUN) && (acc_bits >= 5'd8);
    assign out_last  = out_valid && (byte_cnt_q == last_at_q);
    assign accept    = in_ready && bus.in_valid;
    assign emit      = out_valid && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        npoly_d    = npoly_q;
        coef_cnt_d = coef_cnt_q;
        byte_cnt_d = byte_cnt_q;
        last_at_d  = last_at_q;
        err_d      = 1'b0;
        clear      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (start_legal) begin
                        d_d        = bus.d;
                        npoly_d    = bus.npoly;
                        coef_cnt_d = '0;
                        byte_cnt_d = '0;
                        last_at_d  = bytes_per_poly(bus.d) - 11'd1;
                        clear      = 1'b1;
                        state_d    = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    coef_cnt_d = coef_cnt_q + 11'd1;
                end
                if (emit) begin
                    byte_cnt_d = byte_cnt_q + 11'd1;
                    if (out_last) begin
                        last_at_d = last_at_q + bytes_per_poly(d_q);
                    end
                end
                // Every polynomial is a whole number of bytes, so nothing is left to flush.
                if ((coef_cnt_q == coef_total) && (acc_bits == 5'd0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            d_q        <= '0;
            npoly_q    <= '0;
            coef_cnt_q <= '0;
            byte_cnt_q <= '0;
            last_at_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            npoly_q    <= npoly_d;
            coef_cnt_q <= coef_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            last_at_q  <= last_at_d;
            err_q      <= err_d;
        end
    end

    encode_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear),
        .d_i        (d_q),
        .accept_i   (accept),
        .coef_i     (bus.in_coef[D_MAX-1:0]),
        .emit_i     (emit),
        .acc_bits_o (acc_bits),
        .byte_o     (acc_byte)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_byte  = acc_byte;
    assign bus.out_last  = out_last;
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_encode_ctrl.sv
// Scoreboard bench for encode_ctrl: a bit-stream reference model fills the expected queue.
module tb_encode_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    encode_ctrl_if bus ();

    encode_ctrl #(
        .N_POLY_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int done_cyc = 0;
    int rx_bytes = 0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_b = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expected byte per output handshake, checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.err) err_cnt++;
            if (hold_v) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_byte", 32'(bus.out_byte), 32'(hold_b));
            end
            hold_v = 1'b0;
            if (bus.out_valid) begin
                chk("in_out_exclusive", 32'(bus.in_ready), 32'd0);
                if (bus.out_ready) begin
                    rx_bytes++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", bus.out_byte);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("out_byte", 32'(bus.out_byte), 32'(mon_e.b));
                        chk("out_last", 32'(bus.out_last), 32'(mon_e.last));
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_b = bus.out_byte;
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.d         = 4'd0;
        bus.npoly     = 3'd0;
        bus.in_valid  = 1'b0;
        bus.in_coef   = 16'h0000;
        bus.out_ready = 1'b0;
    endtask

    // Called just after a rising edge; reset applies on the next edge and is released after.
    task automatic reset_check();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_byte", 32'(bus.out_byte), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // mode: 0 random, 1 alternating 1/0, 2 0xABC,0x123 then random, 3 0xFFF0/0x0001
    task automatic run_cmd(input int d, input int np, input int mode, input bit rnd_in,
                           input bit rnd_out, input int abort_at, input bit poke_start);
        logic [15:0] coefs[$];
        bit          s[$];
        logic [15:0] c;
        exp_t        e;
        int          n, nb, idx, t, st_cyc, err0, done0, rx0;
        bit          got_done, aborted;

        n = 256 * np;
        for (int i = 0; i < n; i++) begin
            case (mode)
                1:       c = (i % 2 == 0) ? 16'h0001 : 16'h0000;
                2:       c = (i == 0) ? 16'h0ABC : (i == 1) ? 16'h0123 : 16'($urandom);
                3:       c = (i % 2 == 0) ? 16'hFFF0 : 16'h0001;
                default: c = 16'($urandom);
            endcase
            coefs.push_back(c);
        end
        // Reference: flat LSB-first bit stream, then cut into bytes.
        for (int i = 0; i < n; i++) begin
            c = coefs[i];
            for (int j = 0; j < d; j++) s.push_back(c[j]);
        end
        nb = s.size() / 8;
        for (int k = 0; k < nb; k++) begin
            e.b = 8'h00;
            for (int b = 0; b < 8; b++) e.b[b] = s[8 * k + b];
            e.last = ((k % (32 * d)) == (32 * d - 1));
            exp_q.push_back(e);
        end

        err0  = err_cnt;
        done0 = done_cnt;
        rx0   = rx_bytes;
        bus.start     = 1'b1;
        bus.d         = 4'(d);
        bus.npoly     = 3'(np);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        st_cyc   = cyc;
        idx      = 0;
        t        = 0;
        got_done = 1'b0;
        aborted  = 1'b0;

        while (!got_done && !aborted && t < 20000) begin
            @(posedge clk);
            #1;
            t++;
            bus.start = poke_start && (idx == 50);
            bus.d     = bus.start ? 4'd13 : 4'(d);
            if (abort_at >= 0 && idx == abort_at) begin
                reset_check();
                chk("abort_no_done", 32'(done_cnt - done0), 32'd0);
                aborted = 1'b1;
            end else begin
                bus.in_valid  = (idx < n) && (rnd_in ? ($urandom_range(1, 0) == 1) : 1'b1);
                bus.in_coef   = bus.in_valid ? coefs[idx] : 16'($urandom);
                bus.out_ready = rnd_out ? ($urandom_range(1, 0) == 1) : 1'b1;
                @(negedge clk);
                if (t == 1) begin
                    chk("first_in_ready", 32'(bus.in_ready), 32'd1);
                    chk("busy_run", 32'(bus.busy), 32'd1);
                end
                if (bus.in_valid && bus.in_ready) idx++;
                if (bus.done) got_done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;

        if (!aborted) begin
            chk("done_seen", 32'(got_done), 32'd1);
            @(negedge clk);
            chk("done_pulse_len", 32'(bus.done), 32'd0);
            chk("busy_after_done", 32'(bus.busy), 32'd0);
            chk("done_count", 32'(done_cnt - done0), 32'd1);
            chk("byte_count", 32'(rx_bytes - rx0), 32'(32 * d * np));
            chk("queue_empty", 32'(exp_q.size()), 32'd0);
            chk("no_err", 32'(err_cnt - err0), 32'd0);
            if (!rnd_in && !rnd_out)
                chk("latency", 32'(done_cyc - st_cyc), 32'(2 + np * (256 + 32 * d)));
            if (!got_done) begin
                @(posedge clk);
                #1;
                reset_check();
            end else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic err_test(input int d, input int np);
        int e0;
        e0 = err_cnt;
        bus.start = 1'b1;
        bus.d     = 4'(d);
        bus.npoly = 3'(np);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("err_pulse", 32'(bus.err), 32'd1);
        chk("err_busy", 32'(bus.busy), 32'd0);
        chk("err_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("err_clear", 32'(bus.err), 32'd0);
        chk("err_stays_idle", 32'(bus.busy), 32'd0);
        chk("err_count", 32'(err_cnt - e0), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        reset_check();

        run_cmd(1, 1, 1, 1'b0, 1'b0, -1, 1'b0);
        run_cmd(12, 1, 2, 1'b0, 1'b0, -1, 1'b0);
        run_cmd(4, 1, 3, 1'b0, 1'b0, -1, 1'b0);
        run_cmd(10, 3, 0, 1'b1, 1'b1, -1, 1'b1);

        err_test(13, 1);
        err_test(4, 0);
        err_test(0, 1);
        err_test(8, 5);

        run_cmd(4, 1, 0, 1'b0, 1'b0, 100, 1'b0);
        run_cmd(4, 1, 0, 1'b0, 1'b0, -1, 1'b0);

        for (int r = 0; r < 3; r++)
            run_cmd(int'($urandom_range(12, 1)), int'($urandom_range(2, 1)), 0, 1'b1, 1'b1, -1,
                    1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
